// File: rtl/fpa_pkg.sv
// Shared definitions for the FP adder issue arbiter and its neighbours.
package fpa_pkg;

    localparam int unsigned FP_W = 32;

    // Tag id field is wide enough for up to 8 requesters.
    localparam int unsigned TAG_IDW = 3;

    localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;
    localparam logic [FP_W-1:0] PINF = 32'h7F80_0000;

    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/fpa_issue_arbiter_if.sv
// Requester-side and adder-side signals of the shared adder arbiter.
interface fpa_issue_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    import fpa_pkg::*;

    logic [N_REQ-1:0]      req_valid;
    logic [FP_W*N_REQ-1:0] req_a;
    logic [FP_W*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]      req_ready;
    logic [FP_W-1:0]       fpa_a;
    logic [FP_W-1:0]       fpa_b;
    logic [FP_W-1:0]       fpa_c;
    logic [N_REQ-1:0]      resp_valid;
    logic [FP_W-1:0]       resp_data;
    logic                  busy;

    // Requesters plus the adder: drive requests and the adder result.
    modport master (
        output req_valid, req_a, req_b, fpa_c,
        input  req_ready, fpa_a, fpa_b, resp_valid, resp_data, busy
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_a, req_b, fpa_c,
        output req_ready, fpa_a, fpa_b, resp_valid, resp_data, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// and moves the pointer past the winner when the grant is taken.
module rr_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           advance,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           gnt_any
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW-1:0] idx;

    // Scan from the pointer, wrapping, and stop at the first request.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IDW'((32'(ptr_q) + k) % N);
            if (!gnt_any && req[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

    // Next pointer: one past the winner, modulo N; hold when nothing is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && gnt_any) begin
            ptr_d = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fpa_issue_arbiter.sv
// Shares one fixed-latency pipelined FP adder among N_REQ requesters.
// Each issued op carries a requester tag down a delay line matched to the
// adder, so the result can be routed back to its owner without stalling.
module fpa_issue_arbiter
    import fpa_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned LAT     = 6,
    parameter int unsigned MAX_OUT = 2,
    parameter int unsigned IDW     = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    fpa_issue_arbiter_if.slave  bus
);

    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_id;
    logic             gnt_any;
    logic             issue;
    logic [FP_W-1:0]  sel_a;
    logic [FP_W-1:0]  sel_b;
    logic [FP_W-1:0]  fpa_a_q;
    logic [FP_W-1:0]  fpa_b_q;
    tag_t             tag_q [LAT];
    tag_t             tag_exit;
    logic [N_REQ-1:0] retire;
    logic [CW-1:0]    out_cnt_q [N_REQ];
    logic [CW-1:0]    out_cnt_d [N_REQ];
    logic [N_REQ-1:0] resp_valid_q;
    logic [FP_W-1:0]  resp_data_q;
    logic             busy_c;

    // A requester competes only while it has a pending op and a free credit.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            eligible[i] = bus.req_valid[i] && (out_cnt_q[i] < CW'(MAX_OUT));
        end
    end

    rr_arbiter #(
        .N   (N_REQ),
        .IDW (IDW)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (eligible),
        .advance (issue),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    assign issue = gnt_any && !rst;

    // One-hot operand mux for the winner.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_a = bus.req_a[i*FP_W +: FP_W];
                sel_b = bus.req_b[i*FP_W +: FP_W];
            end
        end
    end

    // Operand registers feeding the adder; they hold when nothing issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpa_a_q <= '0;
            fpa_b_q <= '0;
        end else if (issue) begin
            fpa_a_q <= sel_a;
            fpa_b_q <= sel_b;
        end
    end

    // Tag delay line: stage0 plus LAT-1 stages, exiting alongside fpa_c.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned j = 0; j < LAT; j++) begin
                tag_q[j] <= '0;
            end
        end else begin
            tag_q[0].valid <= issue;
            tag_q[0].id    <= issue ? TAG_IDW'(gnt_id) : '0;
            for (int unsigned j = 1; j < LAT; j++) begin
                tag_q[j] <= tag_q[j-1];
            end
        end
    end

    assign tag_exit = tag_q[LAT-1];

    // Retire decode and credit next-state; a grant and a retire cancel out.
    always_comb begin
        retire = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            retire[i]    = tag_exit.valid && (tag_exit.id == TAG_IDW'(i));
            out_cnt_d[i] = out_cnt_q[i];
            if (issue && gnt[i] && !retire[i]) begin
                out_cnt_d[i] = out_cnt_q[i] + CW'(1);
            end else if (retire[i] && !(issue && gnt[i])) begin
                out_cnt_d[i] = out_cnt_q[i] - CW'(1);
            end
        end
    end

    // Credit counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                out_cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                out_cnt_q[i] <= out_cnt_d[i];
            end
        end
    end

    // Registered response: route the emerging adder result to the tag owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= retire;
            if (tag_exit.valid) begin
                resp_data_q <= bus.fpa_c;
            end
        end
    end

    // Credit sanity: no retire without an outstanding op, never above MAX_OUT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                assert (!(retire[i] && (out_cnt_q[i] == '0)));
                assert (out_cnt_q[i] <= CW'(MAX_OUT));
            end
        end
    end

    // Busy while any credit is held or any valid tag is in the line.
    always_comb begin
        busy_c = 1'b0;
        for (int unsigned j = 0; j < LAT; j++) begin
            busy_c = busy_c | tag_q[j].valid;
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            busy_c = busy_c | (out_cnt_q[i] != '0);
        end
    end

    assign bus.req_ready  = rst ? '0 : gnt;
    assign bus.fpa_a      = fpa_a_q;
    assign bus.fpa_b      = fpa_b_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.busy       = busy_c;

endmodule
